// File: rtl/rob_commit_unit_if.sv
// ============================================================================
// Module   : rob_commit_unit_if
// Brief    : Dispatch, CDB and commit bundle of the reorder-buffer retire unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface rob_commit_unit_if #(
  parameter int SIZE         = 8,
  parameter int COMMIT_WIDTH = 2,
  parameter int TAG_W        = $clog2(SIZE)
);
  localparam int c_ndq_w = $clog2(COMMIT_WIDTH + 1);

  logic                      enq_valid;
  logic [31:0]               enq_pc;
  logic [4:0]                enq_rd;
  logic                      enq_is_br;
  logic                      enq_ready;
  logic [TAG_W-1:0]          enq_tag;

  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [31:0]               cdb_data;
  logic                      cdb_mispredict;
  logic [31:0]               cdb_target;

  logic                      commit;
  logic [c_ndq_w-1:0]        num_deq;
  logic [TAG_W-1:0]          front_tag;
  logic [COMMIT_WIDTH-1:0]   rf_we;
  logic [5*COMMIT_WIDTH-1:0] rf_rd;
  logic [32*COMMIT_WIDTH-1:0] rf_data;
  logic                      flush;
  logic [31:0]               redirect_pc;

  modport master (
    output enq_valid, enq_pc, enq_rd, enq_is_br,
    output cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target,
    input  enq_ready, enq_tag,
    input  commit, num_deq, front_tag, rf_we, rf_rd, rf_data, flush, redirect_pc
  );

  modport slave (
    input  enq_valid, enq_pc, enq_rd, enq_is_br,
    input  cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target,
    output enq_ready, enq_tag,
    output commit, num_deq, front_tag, rf_we, rf_rd, rf_data, flush, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/rob_commit_unit.sv
// ============================================================================
// Module   : rob_commit_unit
// Brief    : In-order ROB retire: allocate, collect CDB results, commit up to
//            COMMIT_WIDTH entries per cycle, flush on a retiring mispredict.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rob_commit_unit #(
  parameter int SIZE         = 8,
  parameter int COMMIT_WIDTH = 2,
  parameter int TAG_W        = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  rob_commit_unit_if.slave  bus
);
  localparam int c_ndq_w = $clog2(COMMIT_WIDTH + 1);
  localparam int c_cnt_w = TAG_W + 1;

  logic [SIZE-1:0]    r_valid;
  logic [SIZE-1:0]    r_ready;
  logic [SIZE-1:0]    r_is_br;
  logic [SIZE-1:0]    r_mis;
  logic [31:0]        r_pc     [SIZE];
  logic [31:0]        r_data   [SIZE];
  logic [31:0]        r_target [SIZE];
  logic [4:0]         r_rd     [SIZE];
  logic [TAG_W-1:0]   r_head;
  logic [TAG_W-1:0]   r_tail;
  logic [c_cnt_w-1:0] r_count;

  logic [TAG_W-1:0]        w_lane_idx [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] w_ret;
  logic [c_ndq_w-1:0]      w_n;
  logic                    w_go;
  logic                    w_flush;
  logic [31:0]             w_target;
  logic                    w_enq_acc;
  logic                    w_cdb_hit;
  logic [TAG_W-1:0]        w_head_next;

  genvar k;
  generate
    for (k = 0; k < COMMIT_WIDTH; k++) begin : g_lane
      assign w_lane_idx[k] = r_head + TAG_W'(k);
    end
  endgenerate

  // Retire a contiguous run of ready entries; a mispredicted branch ends the run.
  always_comb begin
    w_ret    = '0;
    w_n      = '0;
    w_go     = 1'b1;
    w_flush  = 1'b0;
    w_target = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (w_go && r_valid[w_lane_idx[i]] && r_ready[w_lane_idx[i]]) begin
        w_ret[i] = 1'b1;
        w_n      = w_n + c_ndq_w'(1);
        if (r_is_br[w_lane_idx[i]] && r_mis[w_lane_idx[i]]) begin
          w_go     = 1'b0;
          w_flush  = 1'b1;
          w_target = r_target[w_lane_idx[i]];
        end
      end else begin
        w_go = 1'b0;
      end
    end
  end

  assign bus.enq_ready = (r_count != c_cnt_w'(SIZE));
  assign bus.enq_tag   = r_tail;
  assign w_enq_acc     = bus.enq_valid && bus.enq_ready;
  assign w_cdb_hit     = bus.cdb_valid && r_valid[bus.cdb_tag];
  assign w_head_next   = r_head + TAG_W'(w_n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid         <= '0;
      r_ready         <= '0;
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      bus.commit      <= 1'b0;
      bus.num_deq     <= '0;
      bus.front_tag   <= '0;
      bus.rf_we       <= '0;
      bus.rf_rd       <= '0;
      bus.rf_data     <= '0;
      bus.flush       <= 1'b0;
      bus.redirect_pc <= '0;
    end else begin
      bus.commit  <= |w_ret;
      bus.num_deq <= w_n;
      if (|w_ret) bus.front_tag <= r_head;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        bus.rf_we[i] <= w_ret[i] && (r_rd[w_lane_idx[i]] != 5'd0);
        if (w_ret[i]) begin
          bus.rf_rd[5*i +: 5]    <= r_rd[w_lane_idx[i]];
          bus.rf_data[32*i +: 32] <= r_data[w_lane_idx[i]];
        end
      end
      bus.flush <= w_flush;
      if (w_flush) bus.redirect_pc <= w_target;

      if (w_cdb_hit) r_ready[bus.cdb_tag] <= 1'b1;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (w_ret[i]) begin
          r_valid[w_lane_idx[i]] <= 1'b0;
          r_ready[w_lane_idx[i]] <= 1'b0;
        end
      end

      r_head <= w_head_next;
      if (w_flush) begin
        r_valid <= '0;
        r_ready <= '0;
        r_tail  <= w_head_next;
        r_count <= '0;
      end else begin
        if (w_enq_acc) begin
          r_valid[r_tail] <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_tail          <= r_tail + TAG_W'(1);
        end
        r_count <= r_count + c_cnt_w'(w_enq_acc) - c_cnt_w'(w_n);
      end
    end
  end

  // Payload storage is qualified by valid/ready, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_enq_acc && !w_flush) begin
      r_pc[r_tail]    <= bus.enq_pc;
      r_rd[r_tail]    <= bus.enq_rd;
      r_is_br[r_tail] <= bus.enq_is_br;
      r_mis[r_tail]   <= 1'b0;
    end
    if (w_cdb_hit) begin
      r_data[bus.cdb_tag]   <= bus.cdb_data;
      r_mis[bus.cdb_tag]    <= bus.cdb_mispredict;
      r_target[bus.cdb_tag] <= bus.cdb_target;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_rob_commit_unit.sv
// ============================================================================
// Module   : tb_rob_commit_unit
// Brief    : Scoreboard bench for rob_commit_unit against a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rob_commit_unit;
  localparam int SIZE  = 8;
  localparam int CW    = 2;
  localparam int TAG_W = 3;

  typedef struct {
    bit        rdy;
    bit [4:0]  rd;
    bit        br;
    bit [31:0] data;
    bit        mis;
    bit [31:0] tgt;
  } ent_t;

  typedef struct {
    bit        commit;
    bit [1:0]  ndq;
    bit [2:0]  front;
    bit [1:0]  we;
    bit [9:0]  rd;
    bit [63:0] data;
    bit        flush;
    bit [31:0] redir;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ent_t             m_q[$];
  exp_t             exp_q[$];
  exp_t             m_last;
  logic [TAG_W-1:0] m_head;
  logic [TAG_W-1:0] m_tail;

  rob_commit_unit_if #(.SIZE(SIZE), .COMMIT_WIDTH(CW), .TAG_W(TAG_W)) bus ();

  rob_commit_unit #(.SIZE(SIZE), .COMMIT_WIDTH(CW), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_head = '0;
    m_tail = '0;
    m_last = '{default: '0};
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_commit"},  64'(bus.commit), 64'd0);
    check({pfx, "_ndq"},     64'(bus.num_deq), 64'd0);
    check({pfx, "_front"},   64'(bus.front_tag), 64'd0);
    check({pfx, "_we"},      64'(bus.rf_we), 64'd0);
    check({pfx, "_rd"},      64'(bus.rf_rd), 64'd0);
    check({pfx, "_data"},    bus.rf_data, 64'd0);
    check({pfx, "_flush"},   64'(bus.flush), 64'd0);
    check({pfx, "_redir"},   64'(bus.redirect_pc), 64'd0);
    check({pfx, "_ready"},   64'(bus.enq_ready), 64'd1);
    check({pfx, "_tag"},     64'(bus.enq_tag), 64'd0);
  endtask

  task automatic enq(input logic [31:0] pc, input logic [4:0] rd, input bit br);
    bus.enq_valid = 1'b1;
    bus.enq_pc    = pc;
    bus.enq_rd    = rd;
    bus.enq_is_br = br;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [31:0] d, input bit mis, input logic [31:0] tgt);
    bus.cdb_valid      = 1'b1;
    bus.cdb_tag        = tag;
    bus.cdb_data       = d;
    bus.cdb_mispredict = mis;
    bus.cdb_target     = tgt;
  endtask

  // Predict the coming edge from the model, push it, take the edge, compare.
  task automatic step();
    exp_t e;
    exp_t g;
    bit   acc;
    int   n;
    int   off;
    bit   fl;
    check("enq_ready", 64'(bus.enq_ready), 64'(m_q.size() != SIZE));
    check("enq_tag", 64'(bus.enq_tag), 64'(m_tail));
    acc = bus.enq_valid && (m_q.size() != SIZE);

    e        = m_last;
    e.commit = 1'b0;
    e.ndq    = '0;
    e.we     = '0;
    e.flush  = 1'b0;
    n  = 0;
    fl = 1'b0;
    for (int k = 0; k < CW; k++) begin
      if (k >= m_q.size() || !m_q[k].rdy) break;
      n++;
      e.we[k]         = (m_q[k].rd != 5'd0);
      e.rd[5*k +: 5]  = m_q[k].rd;
      e.data[32*k +: 32] = m_q[k].data;
      if (m_q[k].br && m_q[k].mis) begin
        fl      = 1'b1;
        e.redir = m_q[k].tgt;
        break;
      end
    end
    if (n > 0) begin
      e.commit = 1'b1;
      e.ndq    = 2'(n);
      e.front  = m_head;
    end
    e.flush = fl;
    m_last  = e;
    exp_q.push_back(e);

    if (bus.cdb_valid) begin
      off = (int'(bus.cdb_tag) - int'(m_head) + SIZE) % SIZE;
      if (off < m_q.size()) begin
        m_q[off].rdy  = 1'b1;
        m_q[off].data = bus.cdb_data;
        m_q[off].mis  = bus.cdb_mispredict;
        m_q[off].tgt  = bus.cdb_target;
      end
    end
    for (int k = 0; k < n; k++) void'(m_q.pop_front());
    m_head = m_head + 3'(n);
    if (fl) begin
      m_q.delete();
      m_tail = m_head;
    end else if (acc) begin
      m_q.push_back('{rdy: 1'b0, rd: bus.enq_rd, br: bus.enq_is_br, data: 32'd0, mis: 1'b0, tgt: 32'd0});
      m_tail = m_tail + 3'd1;
    end

    @(posedge clk);
    #1;
    bus.enq_valid = 1'b0;
    bus.cdb_valid = 1'b0;
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      g = exp_q.pop_front();
      check("commit",  64'(bus.commit), 64'(g.commit));
      check("num_deq", 64'(bus.num_deq), 64'(g.ndq));
      check("front",   64'(bus.front_tag), 64'(g.front));
      check("rf_we",   64'(bus.rf_we), 64'(g.we));
      check("rf_rd",   64'(bus.rf_rd), 64'(g.rd));
      check("rf_data", bus.rf_data, g.data);
      check("flush",   64'(bus.flush), 64'(g.flush));
      check("redir",   64'(bus.redirect_pc), 64'(g.redir));
    end
  endtask

  initial begin
    bus.enq_valid = 1'b0; bus.enq_pc = '0; bus.enq_rd = '0; bus.enq_is_br = 1'b0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
    bus.cdb_mispredict = 1'b0; bus.cdb_target = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("rst0");
    rst = 1'b1;

    // Three entries, results arrive out of order (tag 0 last).
    enq(32'h60, 5'd1, 1'b0); step();
    enq(32'h64, 5'd2, 1'b0); step();
    enq(32'h68, 5'd3, 1'b0); step();
    cdb(3'd1, 32'hB, 1'b0, 32'h0); step();
    cdb(3'd2, 32'hC, 1'b0, 32'h0); step();
    cdb(3'd0, 32'hA, 1'b0, 32'h0); step();
    check("t1_wait", 64'(bus.commit), 64'd0);
    step();
    check("t1_ndq2", 64'(bus.num_deq), 64'd2);
    check("t1_front0", 64'(bus.front_tag), 64'd0);
    check("t1_rd", 64'(bus.rf_rd), 64'({5'd2, 5'd1}));
    check("t1_data", bus.rf_data, {32'hB, 32'hA});
    step();
    check("t1_ndq1", 64'(bus.num_deq), 64'd1);
    check("t1_front2", 64'(bus.front_tag), 64'd2);
    check("t1_x3", 64'(bus.rf_rd[4:0]), 64'd3);

    // Fill to full (tail wraps), refuse a ninth, drain one per cycle.
    for (int i = 0; i < 8; i++) begin
      enq(32'h200 + 32'(4 * i), (i == 2) ? 5'd0 : 5'(i + 8), 1'b0);
      step();
    end
    check("full_ready", 64'(bus.enq_ready), 64'd0);
    enq(32'h300, 5'd9, 1'b0); step();
    for (int i = 0; i < 8; i++) begin
      cdb(3'(3 + i), 32'h1000 + 32'(i), 1'b0, 32'h0);
      if (i == 1) enq(32'h304, 5'd10, 1'b0);
      step();
      if (i == 1) check("ready_after_deq", 64'(bus.enq_ready), 64'd1);
    end
    step(); step();

    // Mispredicted branch at tag 3 with younger ready entries behind it.
    check("t4_tail3", 64'(bus.enq_tag), 64'd3);
    enq(32'h400, 5'd0, 1'b1); step();
    enq(32'h404, 5'd4, 1'b0); step();
    enq(32'h408, 5'd5, 1'b0); step();
    cdb(3'd4, 32'h44, 1'b0, 32'h0); step();
    cdb(3'd5, 32'h55, 1'b0, 32'h0); step();
    cdb(3'd3, 32'h33, 1'b1, 32'h100); step();
    check("t4_wait", 64'(bus.commit), 64'd0);
    enq(32'h40C, 5'd6, 1'b0); step();
    check("t4_commit", 64'(bus.commit), 64'd1);
    check("t4_ndq", 64'(bus.num_deq), 64'd1);
    check("t4_front", 64'(bus.front_tag), 64'd3);
    check("t4_flush", 64'(bus.flush), 64'd1);
    check("t4_redir", 64'(bus.redirect_pc), 64'h100);
    step();
    check("t4_flush_off", 64'(bus.flush), 64'd0);
    check("t4_tag_after", 64'(bus.enq_tag), 64'd4);
    step(); step();

    // Asynchronous reset with five entries pending and a commit in flight.
    for (int i = 0; i < 5; i++) begin
      enq(32'h500 + 32'(4 * i), 5'(11 + i), 1'b0);
      step();
    end
    cdb(3'd4, 32'h77, 1'b0, 32'h0); step();
    cdb(3'd5, 32'h78, 1'b0, 32'h0); step();
    check("t5_commit_pre", 64'(bus.commit), 64'd1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst1");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(); step();
    check("t5_no_commit", 64'(bus.commit), 64'd0);
    check("t5_tag0", 64'(bus.enq_tag), 64'd0);
    enq(32'h600, 5'd7, 1'b0); step();
    cdb(3'd0, 32'h99, 1'b0, 32'h0); step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
